// File: rtl/sram_pkg.sv
// Shared types, helpers and legal-parameter ranges for the sram_1rw_wmask macro family.
package sram_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } sram_state_e;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    function automatic int calc_wmask_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// READ_LATENCY-deep read data/valid shift register; the last stage only loads on a valid
// beat so the output word holds between reads. Async reset flushes all stages.
module sram_rd_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 1
) (
    input  logic                  clk0,
    input  logic                  rst0_n,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data
);

    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
        logic                  r_vld;
        logic [DATA_WIDTH-1:0] r_dat;
        logic                  w_vld_in;
        logic [DATA_WIDTH-1:0] w_dat_in;

        if (gi == 0) begin : g_head
            assign w_vld_in = i_valid;
            assign w_dat_in = i_data;
        end else begin : g_tail
            assign w_vld_in = g_stage[gi-1].r_vld;
            assign w_dat_in = g_stage[gi-1].r_dat;
        end

        always_ff @(posedge clk0 or negedge rst0_n) begin
            if (!rst0_n) begin
                r_vld <= 1'b0;
                r_dat <= '0;
            end else begin
                r_vld <= w_vld_in;
                if (w_vld_in) begin
                    r_dat <= w_dat_in;
                end
            end
        end
    end

    assign o_valid = g_stage[LATENCY-1].r_vld;
    assign o_data  = g_stage[LATENCY-1].r_dat;

endmodule

// File: rtl/sram_1rw_wmask.sv
// Single-port SRAM with byte write mask, ready handshake and out-of-range detection.
// Optional build macro SRAM_INIT_CLEAR_EN: zero every word out of reset before going ready.
module sram_1rw_wmask
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int RAM_DEPTH    = 1 << ADDR_WIDTH,
    parameter int WMASK_WIDTH  = calc_wmask_width(DATA_WIDTH),
    parameter int READ_LATENCY = 1
) (
    input  logic                   clk0,
    input  logic                   rst0_n,
    input  logic                   csb0,
    input  logic                   web0,
    input  logic [WMASK_WIDTH-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0]  addr0,
    input  logic [DATA_WIDTH-1:0]  din0,
    output logic                   ready0,
    output logic [DATA_WIDTH-1:0]  dout0,
    output logic                   dout_valid0,
    output logic                   err0
);

    if (READ_LATENCY < RD_LAT_MIN || READ_LATENCY > RD_LAT_MAX) begin : g_bad_latency
        $error("sram_1rw_wmask: READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("sram_1rw_wmask: DATA_WIDTH must be a multiple of 8");
    end
    if (RAM_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("sram_1rw_wmask: RAM_DEPTH exceeds the address space");
    end

    localparam logic [ADDR_WIDTH:0] DEPTH_W = RAM_DEPTH[ADDR_WIDTH:0];

    sram_state_e           r_state;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];
    logic                  w_accept;
    logic                  w_oob;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic                  w_clr_we;
    logic [ADDR_WIDTH-1:0] w_clr_addr;

    // Gating with rst0_n keeps a held reset from accepting writes while ready0 is high.
    assign ready0    = (r_state == ST_READY);
    assign w_accept  = ready0 && !csb0 && rst0_n;
    assign w_oob     = ({1'b0, addr0} >= DEPTH_W);
    assign w_wr_en   = w_accept && !web0 && !w_oob;
    assign w_rd_en   = w_accept && web0;
    assign w_rd_word = w_oob ? '0 : r_mem[addr0];

`ifdef SRAM_INIT_CLEAR_EN
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(RAM_DEPTH - 1);

    logic [ADDR_WIDTH-1:0] r_clr_cnt;

    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            r_state   <= ST_INIT;
            r_clr_cnt <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (r_clr_cnt == LAST_WORD) begin
                        r_state <= ST_READY;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_READY;
            endcase
        end
    end

    assign w_clr_we   = (r_state == ST_INIT);
    assign w_clr_addr = r_clr_cnt;
`else
    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            r_state <= ST_READY;
        end else begin
            r_state <= ST_READY;
        end
    end

    assign w_clr_we   = 1'b0;
    assign w_clr_addr = '0;
`endif

    // No reset on the array so contents survive rst0_n and map onto block RAM.
    always_ff @(posedge clk0) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_wr_en) begin
            for (int b = 0; b < WMASK_WIDTH; b++) begin
                if (wmask0[b]) begin
                    r_mem[addr0][8*b +: 8] <= din0[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept && w_oob;
        end
    end

    assign err0 = r_err;

    sram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (READ_LATENCY)
    ) u_rd_pipe (
        .clk0    (clk0),
        .rst0_n  (rst0_n),
        .i_valid (w_rd_en),
        .i_data  (w_rd_word),
        .o_valid (dout_valid0),
        .o_data  (dout0)
    );

endmodule

// File: tb/tb_sram_1rw_wmask.sv
// Scoreboard bench for sram_1rw_wmask: randomized traffic against a word-array reference model.
module tb_sram_1rw_wmask;

    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int DEPTH = 200;
    localparam int LAT   = 2;
    localparam int WM    = DW / 8;
`ifdef SRAM_INIT_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    logic          clk0 = 1'b0;
    logic          rst0_n;
    logic          csb0;
    logic          web0;
    logic [WM-1:0] wmask0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] din0;
    logic          ready0;
    logic [DW-1:0] dout0;
    logic          dout_valid0;
    logic          err0;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } rd_exp_t;

    rd_exp_t       rd_q[$];
    int            err_q[$];
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] last_exp;
    int            cyc    = 0;
    int            n_cmp  = 0;
    int            n_bad  = 0;
    bit            mon_en = 1'b0;

    sram_1rw_wmask #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .RAM_DEPTH    (DEPTH),
        .WMASK_WIDTH  (WM),
        .READ_LATENCY (LAT)
    ) dut (
        .clk0        (clk0),
        .rst0_n      (rst0_n),
        .csb0        (csb0),
        .web0        (web0),
        .wmask0      (wmask0),
        .addr0       (addr0),
        .din0        (din0),
        .ready0      (ready0),
        .dout0       (dout0),
        .dout_valid0 (dout_valid0),
        .err0        (err0)
    );

    always #5 clk0 = ~clk0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge and retires scoreboard entries.
    initial begin
        rd_exp_t e;
        forever begin
            @(posedge clk0);
            cyc++;
            #1;
            if (mon_en) begin
                if (!rst0_n) begin
                    check("rst_dout", dout0, '0);
                    check("rst_valid", dout_valid0, 1'b0);
                    check("rst_err", err0, 1'b0);
                end else begin
                    if (dout_valid0) begin
                        if (rd_q.size() == 0) begin
                            check("unexpected_valid", 1, 0);
                        end else begin
                            e = rd_q.pop_front();
                            check("rd_data", dout0, e.data);
                            check("rd_latency", cyc, e.cyc);
                            last_exp = e.data;
                        end
                    end else begin
                        check("dout_hold", dout0, last_exp);
                        if (rd_q.size() != 0 && rd_q[0].cyc <= cyc) begin
                            void'(rd_q.pop_front());
                            check("missing_valid", 0, 1);
                        end
                    end
                    if (err0) begin
                        if (err_q.size() != 0 && err_q[0] == cyc) begin
                            check("err_pulse", err0, 1'b1);
                            void'(err_q.pop_front());
                        end else begin
                            check("unexpected_err", 1, 0);
                        end
                    end else if (err_q.size() != 0 && err_q[0] <= cyc) begin
                        void'(err_q.pop_front());
                        check("missing_err", 0, 1);
                    end
                end
            end
        end
    end

    task automatic idle();
        csb0   = 1'b1;
        web0   = 1'($urandom);
        wmask0 = WM'($urandom);
        addr0  = AW'($urandom);
        din0   = $urandom;
        @(negedge clk0);
    endtask

    // Called at a falling edge; the request is accepted (or not) at the next rising edge.
    task automatic req(input bit we_n, input logic [WM-1:0] m, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
        rd_exp_t e;
        csb0   = 1'b0;
        web0   = we_n;
        wmask0 = m;
        addr0  = a;
        din0   = d;
        if (ready0 && rst0_n) begin
            if (a >= DEPTH) err_q.push_back(cyc + 1);
            if (we_n) begin
                e.data = (a >= DEPTH) ? '0 : model[a];
                e.cyc  = cyc + LAT;
                rd_q.push_back(e);
            end else if (a < DEPTH) begin
                for (int b = 0; b < WM; b++) begin
                    if (m[b]) model[a][8*b +: 8] = d[8*b +: 8];
                end
            end
        end
        @(negedge clk0);
    endtask

    task automatic assert_reset(input int hold);
        rst0_n = 1'b0;
        rd_q.delete();
        err_q.delete();
        last_exp = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CLEAR_EN) model[i] = '0;
        end
        repeat (hold) idle();
        check("rst_ready", ready0, CLEAR_EN ? 1'b0 : 1'b1);
    endtask

    // Release at a falling edge and count rising edges until ready0 is seen high.
    task automatic release_and_wait();
        int n;
        n = 0;
        rst0_n = 1'b1;
        while (!ready0 && n < DEPTH + 50) begin
            csb0   = 1'b0;
            web0   = 1'b0;
            wmask0 = '1;
            addr0  = AW'($urandom_range(0, DEPTH - 1));
            din0   = $urandom;
            @(negedge clk0);
            n++;
        end
        csb0 = 1'b1;
        check("init_cycles", n, CLEAR_EN ? DEPTH : 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst0_n = 1'b1; csb0 = 1'b1; web0 = 1'b1; wmask0 = '0; addr0 = '0; din0 = '0;
        last_exp = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        #2;
        mon_en = 1'b1;
        assert_reset(2);
        release_and_wait();

        for (int a = 0; a < DEPTH; a++) req(1'b0, '1, AW'(a), $urandom);

        req(1'b0, 4'hF, 8'h10, 32'hDEADBEEF);
        req(1'b0, 4'b0101, 8'h10, 32'h11223344);
        req(1'b1, 4'h0, 8'h10, 32'h0);
        idle();

        for (int a = 0; a < 8; a++) req(1'b0, '1, AW'(a), $urandom);
        for (int a = 0; a < 8; a++) req(1'b1, '0, AW'(a), '0);
        idle();

        req(1'b0, '1, 8'hC8, 32'hA5A5A5A5);
        req(1'b1, '0, 8'hC8, '0);
        req(1'b1, '0, 8'hFF, '0);
        req(1'b0, '0, 8'h20, $urandom);
        req(1'b1, '0, 8'h20, '0);

        repeat (3000) begin
            if ($urandom_range(0, 4) == 0) idle();
            else req(1'($urandom), WM'($urandom), AW'($urandom), $urandom);
        end

        req(1'b1, '0, 8'h05, '0);
        req(1'b1, '0, 8'h06, '0);
        assert_reset(2);
        release_and_wait();
        for (int a = 0; a < DEPTH; a++) req(1'b1, '0, AW'(a), '0);

        assert_reset(2);
        rst0_n = 1'b1;
        repeat (100) idle();
        assert_reset(2);
        release_and_wait();

        repeat (300) begin
            if ($urandom_range(0, 3) == 0) idle();
            else req(1'($urandom), WM'($urandom), AW'($urandom), $urandom);
        end

        repeat (LAT + 3) idle();
        check("drain_rd", rd_q.size(), 0);
        check("drain_err", err_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_1rw_wmask.md
# sram_1rw_wmask

Parametrised single-port (1RW) synchronous SRAM model: the next generation of our OpenRAM-style macros, generalised in word width, depth and read latency. It adds per-byte write masking, an explicit ready/valid handshake and out-of-range address detection. It serves as the instruction/data memory for the RV32I core in simulation and in FPGA builds, so it must be fully synthesisable: no `#` delays and no X-driving of outputs.

## Interface
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8, address width.
- RAM_DEPTH, 1<<ADDR_WIDTH, number of words; must be ≤ 2^ADDR_WIDTH.
- WMASK_WIDTH, DATA_WIDTH/8, number of byte-enable bits.
- READ_LATENCY, 1, accept-to-data latency in cycles; legal values are 1 or 2.
- clk0  in  1  clock; all state changes on the rising edge.
- rst0_n  in  1  asynchronous active-low reset.
- csb0  in  1  active-low chip select (request).
- web0  in  1  active-low write enable; 1 selects a read.
- wmask0  in  WMASK_WIDTH  byte enables for writes; bit i covers din0[8i+7:8i].
- addr0  in  ADDR_WIDTH  word address.
- din0  in  DATA_WIDTH  write data.
- ready0  out  1  block can accept a request this cycle.
- dout0  out  DATA_WIDTH  read data; holds its value between reads.
- dout_valid0  out  1  one-cycle pulse marking dout0 as new.
- err0  out  1  one-cycle pulse when an accepted request had addr0 ≥ RAM_DEPTH.

## Operation
- A request is accepted on a rising edge where csb0=0 and ready0=1. Requests presented while ready0=0 are ignored and are not queued.
- **Write** (web0=0): bytes with wmask0[i]=1 are written at the accept edge; the other bytes are unchanged. wmask0=0 is a legal no-op write. No dout_valid0 pulse is produced.
- **Read** (web0=1): the word at addr0 as stored after the accept edge is presented on dout0. A read issued the cycle after a write to the same address returns the new data.
- **Out-of-range address** (addr0 ≥ RAM_DEPTH):
  - A write is dropped and the memory is unchanged.
  - A read returns 0 with the normal latency and the normal dout_valid0 pulse.
  - err0 pulses in the cycle after acceptance, for both reads and writes.
- Throughput is one request per cycle while ready0=1. Reads and writes may be interleaved freely; there is no turnaround bubble.
- The state machine has two states: ST_INIT and ST_READY.
  - ST_INIT exists only when the init-clear feature is built in (see Configuration).
  - ready0 = (state == ST_READY).

## Timing
- Read latency: a read accepted at edge N drives dout0 and raises dout_valid0 at edge N+READ_LATENCY.
  - Both are registered.
  - dout_valid0 falls at the next edge unless another read result is arriving.
- err0 is registered and pulses at edge N+1.
- Reset (asynchronous assert, synchronous release):
  - dout0=0, dout_valid0=0, err0=0.
  - The read pipeline is flushed, so in-flight reads produce no valid pulse.
  - Memory contents are preserved unless the init-clear feature is built in.
- ready0 reset value is 0 with the init-clear feature and 1 without it.
- Reset asserted mid-init restarts the clear from word 0.

## Configuration
- Macro: SRAM_INIT_CLEAR_EN.
- Defined:
  - Out of reset the FSM enters ST_INIT, and a counter writes 0 to words 0..RAM_DEPTH-1, one word per cycle.
  - ready0 rises at the edge after the last clear write, i.e. RAM_DEPTH cycles after reset release. Then state = ST_READY.
  - csb0 is ignored during ST_INIT.
- Undefined:
  - There is no ST_INIT state and no clear counter; the block resets directly into ST_READY.
  - Memory starts with undefined contents, or with $readmemh contents when a hex file is loaded.

## Structure
- Package sram_pkg holds:
  - the state enum (ST_INIT, ST_READY);
  - a function that derives WMASK_WIDTH;
  - a localparam for the legal READ_LATENCY range, checked by an elaboration-time assertion.
- One sub-module, sram_rd_pipe: the READ_LATENCY-deep data/valid shift register with async reset and a flush on reset.
- The top level holds the memory array, the byte-mask write logic, the FSM, the clear counter and the err0 logic.

## Test plan
- Build with SRAM_INIT_CLEAR_EN, RAM_DEPTH=256: release reset → ready0=0 for exactly 256 cycles, then 1; a read of addr 0xFF returns 0x00000000.
- Write 0xDEADBEEF to 0x10 with wmask0=4'hF, then write 0x11223344 with wmask0=4'b0101, then read 0x10 → dout0=0xDE22BE44, dout_valid0 at accept+READ_LATENCY, for READ_LATENCY=1 and 2.
- Back-to-back writes then reads to 0x00..0x07 with csb0 held low → 8 consecutive dout_valid0 pulses with the correct data and no bubbles.
- RAM_DEPTH=200, write 0xA5A5A5A5 to addr 0xC8 → err0 pulse, memory unchanged; a read of 0xC8 returns 0 with err0 and dout_valid0.
- Assert rst0_n with 2 reads in flight (READ_LATENCY=2) → no dout_valid0 pulse; dout0=0; previously written data is still readable after reset (build without the macro).
- Assert reset at clear word 100 → after release, ready0 stays low for a full 256 cycles.
